// File: rtl/serial_sub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl_if
// Description : Request/response bundle between a requesting module and the
//               bit-serial subtraction controller.
//                 start  - request, accepted only when controller idle/done
//                 a, b   - unsigned minuend / subtrahend (WIDTH bits)
//                 busy   - controller is stepping through operand bits
//                 done   - one-cycle completion pulse
//                 diff   - (a - b) mod 2^WIDTH, held until next completion
//                 borrow - 1 when a < b, held with diff
//                 zero   - diff == 0 (only with SERIAL_SUB_ZERO_FLAG_EN)
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, a, b, input busy, done, diff, borrow, zero);
  modport slave  (input start, a, b, output busy, done, diff, borrow, zero);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial subtraction controller. Latches two unsigned
//               WIDTH-bit operands on an accepted start and feeds a single
//               full-subtractor cell (two chained half subtractors) one bit
//               per clock, LSB first, with the borrow kept in a register.
//               After WIDTH cycles it presents diff/borrow and pulses done.
// Ports       : clk    - system clock, rising edge
//               rst    - asynchronous active-high reset
//               bus    - serial_sub_ctrl_if.slave (start, a, b, busy, done,
//                        diff, borrow, and zero when enabled)
// Options     : SERIAL_SUB_ZERO_FLAG_EN - adds registered zero flag
//               (diff == 0), updated together with diff.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_sub_ctrl_if.slave   bus
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  // Full subtractor built from two half subtractors:
  //   first  : a - b        -> hd1 = a^b,     hb1 = ~a & b
  //   second : hd1 - br     -> d   = hd1^br,  hb2 = ~hd1 & br
  logic             hd1_d;
  logic             hb1_d;
  logic             hb2_d;
  logic             cell_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  assign hd1_d  = a_sr_q[0] ^ b_sr_q[0];
  assign hb1_d  = ~a_sr_q[0] & b_sr_q[0];
  assign hb2_d  = ~hd1_d & br_q;
  assign cell_d = hd1_d ^ br_q;
  assign br_d   = hb1_d | hb2_d;

  // New bit enters at the MSB; after WIDTH shifts the LSB-first stream has
  // landed in its natural bit positions.
  assign res_d  = (res_q >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic zero_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // start is deliberately not looked at here: no queuing, no reload.
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          res_q  <= res_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_d;
            borrow_q <= br_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q   <= (res_d == '0);
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  assign bus.zero   = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Self-checking bench for serial_sub_ctrl (WIDTH=8). Expected
//               results come from plain integer arithmetic and are queued at
//               request time; a negedge monitor pops one entry per done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Unsigned subtraction modulo 2^W with borrow when a < b.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned av;
    int unsigned bv;
    int unsigned m;
    exp_t e;
    av = a;
    bv = b;
    m  = 1 << W;
    e.borrow = (av < bv);
    e.diff   = W'((av + m - bv) % m);
    e.zero   = (e.diff == '0);
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        n_done++;
        check("busy_low_at_done", bus.busy, 0);
        check("busy_length", busy_run, W);
        busy_run = 0;
        check("done_has_request", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("diff", bus.diff, e.diff);
          check("borrow", bus.borrow, e.borrow);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          check("zero", bus.zero, e.zero);
`endif
        end
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < W + 4) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", bus.done, 1);
  endtask

  // Called at a negedge; returns at a negedge with the controller idle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb_q.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    check("busy_after_accept", bus.busy, 1);
    wait_done(lat);
    check("latency", lat, W);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    int   c;
    int   nd;
    time  t1;
    time  t2;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_borrow", bus.borrow, 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("rst_zero", bus.zero, 0);
`endif
    rst = 1'b0;

    // Directed cases
    do_op(8'h35, 8'h12);
    do_op(8'h00, 8'h01);
    do_op(8'hFF, 8'hFF);

    // Start during RUN cycle 3 must be ignored
    nd        = n_done;
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    sb_q.push_back(model(8'h80, 8'h01));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h00;
    bus.b     = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(c);
    repeat (W + 2) @(negedge clk);
    check("ignored_start_one_done", n_done - nd, 1);
    check("ignored_start_sb_empty", sb_q.size(), 0);

    // Back-to-back with start held high
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    sb_q.push_back(model(8'h10, 8'h20));
    @(negedge clk);
    bus.a     = 8'h20;
    bus.b     = 8'h10;
    sb_q.push_back(model(8'h20, 8'h10));
    wait_done(c);
    t1 = $time;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_reaccept_busy", bus.busy, 1);
    wait_done(c);
    t2 = $time;
    check("b2b_spacing", 32'((t2 - t1) / 10), W + 1);
    @(negedge clk);

    // Asynchronous reset during RUN cycle 4
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h0A;
    sb_q.push_back(model(8'h55, 8'h0A));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_diff", bus.diff, 0);
    check("async_rst_borrow", bus.borrow, 0);
    check("async_rst_done", bus.done, 0);
    sb_q.delete();
    nd = n_done;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("no_done_after_abort", n_done - nd, 0);
    do_op(8'h55, 8'h0A);

    // Randomized operands with random idle gaps
    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
